f_pc_unit: RTL and testbench
============================

Name: f_pc_unit

Overview:
- Fetch-stage program-counter register for the P7 pipelined MIPS CPU.
- Selects the next fetch address from these sources: sequential, branch/jump redirect from D, exception entry, and eret return.
- Drives F_pc to instruction memory and to the fetch exception coder directly downstream.
- Also drives the fetch delay-slot flag and the eret flush strobe.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- F_stall  input  1  hazard-unit stall; hold PC.
- Req  input  1  CP0 exception/interrupt request (already gated by CP0); highest non-reset priority.
- D_eret  input  1  eret instruction currently in D.
- EPC  input  32  CP0 EPC value (forwarded by hazard logic).
- D_redirect  input  1  D-stage branch taken or jump.
- D_target  input  32  redirect target from D-stage NPC logic.
- D_is_jump  input  1  instruction in D is any branch/jump (taken or not).
- F_pc  output  32  current fetch address.
- F_bd  output  1  instruction at F_pc is in a delay slot.
- F_flush  output  1  kill the instruction currently in F (eret has no delay slot).

Behaviour:
- Single 32-bit register pc_q drives F_pc directly; no combinational path from inputs to F_pc.
- Next-PC priority, evaluated every rising edge:
  1. reset -> RESET_PC.
  2. Req -> HANDLER_PC. Overrides stall, eret and redirect in the same cycle.
  3. D_eret and not F_stall -> EPC.
  4. F_stall -> hold pc_q.
  5. D_redirect -> D_target.
  6. Otherwise -> pc_q + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.
- Reset value: F_pc = RESET_PC. In the reset cycle, F_bd = 0 and F_flush = 0.
- Latency:
  - Redirect, eret and exception all take effect at F_pc one cycle after the request cycle.
  - There is no internal buffering. D_redirect and D_eret are sampled only in cycles where F_stall = 0.
  - The hazard unit keeps D frozen during a stall, so a redirect re-presents itself after the stall releases.
- F_bd = D_is_jump & ~reset & ~Req.
  - This is combinational: the instruction in F while a branch is in D is its delay slot.
  - Req forces 0 because the handler fetch is never a delay slot.
- F_flush = D_eret & ~F_stall & ~Req & ~reset.
  - The F/D register uses it to clear the instruction fetched after eret.
- D_eret with F_stall = 1: PC holds and F_flush = 0.
  - This covers an mtc0-EPC hazard still in flight; the eret is retried when the stall drops.
- D_eret and D_redirect are mutually exclusive by decode. If both are asserted, eret wins.
- No alignment or range checking here.
  - Misaligned or out-of-range EPC/D_target values are loaded as-is.
  - The downstream fetch exception coder flags AdEL.
- Reset mid-operation: reset overrides any pending Req/eret/redirect on that edge.
- Illegal PC = 0 is never produced internally except by wrap; it is not treated as special.

Decomposition:
- Shared package (mips_defs) holds RESET_PC, HANDLER_PC, the PC increment constant (4) and the 32-bit word typedef.
- Sub-module f_npc_mux:
  - Purely combinational priority mux producing npc from the inputs above.
  - The top level holds pc_q and the F_bd/F_flush logic, which keeps the priority table unit-testable.

Test Plan:
- Reset held 2 cycles then released, no other inputs -> F_pc = 0x3000, 0x3004, 0x3008 on successive cycles.
- At F_pc = 0x3010: D_redirect = 1, D_target = 0x3100, D_is_jump = 1 for one cycle -> F_bd = 1 that cycle; next F_pc = 0x3100, then 0x3104.
- F_stall = 1 for 3 cycles at F_pc = 0x3020 with D_redirect = 1 -> F_pc stays 0x3020; first cycle after stall drops, F_pc = target.
- Req = 1 together with F_stall = 1, D_eret = 1 and D_redirect = 1 -> next F_pc = 0x4180, F_flush = 0, F_bd = 0.
- D_eret = 1, EPC = 0x3204, F_stall = 0 -> F_flush = 1 that cycle, next F_pc = 0x3204. Same with F_stall = 1 -> F_pc holds, F_flush = 0.
- D_redirect to 0x3001, then sequential from 0xFFFF_FFFC -> F_pc = 0x3001 loaded unchanged, and 0xFFFF_FFFC wraps to 0x0000_0000.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the P7 pipelined MIPS CPU: the machine word type
// and the fixed fetch addresses used by the program-counter logic.
package mips_defs;

    typedef logic [31:0] word_t;

    // First instruction fetched after reset.
    localparam word_t DEF_RESET_PC   = 32'h0000_3000;

    // Common entry point for all exceptions and interrupts.
    localparam word_t DEF_HANDLER_PC = 32'h0000_4180;

    // Distance between consecutive sequential fetches (one word).
    localparam word_t PC_INCR        = 32'h0000_0004;

endpackage : mips_defs

// File: rtl/f_npc_mux.sv
// Next fetch address selection. Purely combinational so the priority order
// between reset, exception entry, eret, stall, redirect and sequential flow
// is kept in one place and can be exercised on its own.
module f_npc_mux
    import mips_defs::*;
#(
    parameter word_t RESET_PC   = DEF_RESET_PC,
    parameter word_t HANDLER_PC = DEF_HANDLER_PC
) (
    input  logic        reset,
    input  logic        req,
    input  logic        d_eret,
    input  logic        f_stall,
    input  logic        d_redirect,
    input  logic [31:0] pc,
    input  logic [31:0] epc,
    input  logic [31:0] d_target,
    output logic [31:0] npc
);

    // Priority chain: an exception request beats the stall so the handler
    // is entered even while the pipeline is frozen; eret is only honoured
    // when not stalled, otherwise the PC simply holds and eret retries.
    always_comb begin
        npc = pc + PC_INCR;
        if (reset) begin
            npc = RESET_PC;
        end else if (req) begin
            npc = HANDLER_PC;
        end else if (d_eret && !f_stall) begin
            npc = epc;
        end else if (f_stall) begin
            npc = pc;
        end else if (d_redirect) begin
            npc = d_target;
        end
    end

endmodule : f_npc_mux

// File: rtl/f_pc_unit.sv
// Fetch-stage program counter. Holds the current fetch address in a single
// register and produces the delay-slot and eret-flush flags for the F/D
// pipeline register.
module f_pc_unit
    import mips_defs::*;
#(
    parameter word_t RESET_PC   = DEF_RESET_PC,
    parameter word_t HANDLER_PC = DEF_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall,
    input  logic        Req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_redirect,
    input  logic [31:0] D_target,
    input  logic        D_is_jump,
    output logic [31:0] F_pc,
    output logic        F_bd,
    output logic        F_flush
);

    word_t pc_q;
    word_t pc_d;
    logic  bd_d;
    logic  flush_d;

    f_npc_mux #(
        .RESET_PC   (RESET_PC),
        .HANDLER_PC (HANDLER_PC)
    ) u_npc_mux (
        .reset      (reset),
        .req        (Req),
        .d_eret     (D_eret),
        .f_stall    (F_stall),
        .d_redirect (D_redirect),
        .pc         (pc_q),
        .epc        (EPC),
        .d_target   (D_target),
        .npc        (pc_d)
    );

    // PC register; the mux already folds reset into pc_d, and the explicit
    // reset branch keeps the register's reset state obvious to synthesis.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Whatever sits in F while a branch/jump is in D is its delay slot,
    // except the handler fetch; eret has no delay slot so its follower dies.
    always_comb begin
        bd_d    = D_is_jump & ~reset & ~Req;
        flush_d = D_eret & ~F_stall & ~Req & ~reset;
    end

    assign F_pc    = pc_q;
    assign F_bd    = bd_d;
    assign F_flush = flush_d;

endmodule : f_pc_unit

// File: tb/tb_f_pc_unit.sv
// Directed testbench for the fetch program counter: reset, sequential flow,
// redirects, stalls, exception priority, eret and address wrap.
module tb_f_pc_unit;

    logic        clk;
    logic        reset;
    logic        F_stall;
    logic        Req;
    logic        D_eret;
    logic [31:0] EPC;
    logic        D_redirect;
    logic [31:0] D_target;
    logic        D_is_jump;
    logic [31:0] F_pc;
    logic        F_bd;
    logic        F_flush;

    int checks = 0;
    int errors = 0;

    f_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .F_stall    (F_stall),
        .Req        (Req),
        .D_eret     (D_eret),
        .EPC        (EPC),
        .D_redirect (D_redirect),
        .D_target   (D_target),
        .D_is_jump  (D_is_jump),
        .F_pc       (F_pc),
        .F_bd       (F_bd),
        .F_flush    (F_flush)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        F_stall    = 1'b0;
        Req        = 1'b0;
        D_eret     = 1'b0;
        EPC        = 32'h0;
        D_redirect = 1'b0;
        D_target   = 32'h0;
        D_is_jump  = 1'b0;
    endtask

    // Single-cycle redirect used to position the PC for later scenarios.
    task automatic jump_to(input logic [31:0] target);
        D_redirect = 1'b1;
        D_target   = target;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset     = 1'b1;
        D_is_jump = 1'b1;
        D_eret    = 1'b1;
        step();
        step();
        checks++;
        if (F_pc !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected %h", F_pc, 32'h0000_3000);
        end
        checks++;
        if (F_bd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bd: got %b expected 0", F_bd);
        end
        checks++;
        if (F_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flush: got %b expected 0", F_flush);
        end
        clear_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (F_pc !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL release_pc: got %h expected %h", F_pc, 32'h0000_3000);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0000_3004;
        exp_pc[1] = 32'h0000_3008;
        exp_pc[2] = 32'h0000_300C;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (F_pc !== exp_pc[i]) begin
                errors++;
                $display("[TB] FAIL seq_%0d: got %h expected %h", i, F_pc, exp_pc[i]);
            end
        end
        step();
        checks++;
        if (F_pc !== 32'h0000_3010) begin
            errors++;
            $display("[TB] FAIL seq_3010: got %h expected %h", F_pc, 32'h0000_3010);
        end
    endtask

    task automatic test_redirect();
        D_redirect = 1'b1;
        D_target   = 32'h0000_3100;
        D_is_jump  = 1'b1;
        #1;
        checks++;
        if (F_bd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL redirect_bd: got %b expected 1", F_bd);
        end
        checks++;
        if (F_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redirect_flush: got %b expected 0", F_flush);
        end
        step();
        clear_inputs();
        checks++;
        if (F_pc !== 32'h0000_3100) begin
            errors++;
            $display("[TB] FAIL redirect_target: got %h expected %h", F_pc, 32'h0000_3100);
        end
        step();
        checks++;
        if (F_pc !== 32'h0000_3104) begin
            errors++;
            $display("[TB] FAIL redirect_next: got %h expected %h", F_pc, 32'h0000_3104);
        end
        // Not-taken branch: still a delay slot, flow stays sequential.
        D_is_jump = 1'b1;
        #1;
        checks++;
        if (F_bd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nottaken_bd: got %b expected 1", F_bd);
        end
        step();
        clear_inputs();
        checks++;
        if (F_pc !== 32'h0000_3108) begin
            errors++;
            $display("[TB] FAIL nottaken_pc: got %h expected %h", F_pc, 32'h0000_3108);
        end
    endtask

    task automatic test_stall();
        jump_to(32'h0000_3020);
        F_stall    = 1'b1;
        D_redirect = 1'b1;
        D_target   = 32'h0000_3200;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (F_pc !== 32'h0000_3020) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, F_pc, 32'h0000_3020);
            end
        end
        F_stall = 1'b0;
        step();
        clear_inputs();
        checks++;
        if (F_pc !== 32'h0000_3200) begin
            errors++;
            $display("[TB] FAIL stall_release: got %h expected %h", F_pc, 32'h0000_3200);
        end
    endtask

    task automatic test_req_priority();
        Req        = 1'b1;
        F_stall    = 1'b1;
        D_eret     = 1'b1;
        EPC        = 32'h0000_5000;
        D_redirect = 1'b1;
        D_target   = 32'h0000_6000;
        D_is_jump  = 1'b1;
        #1;
        checks++;
        if (F_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL req_flush: got %b expected 0", F_flush);
        end
        checks++;
        if (F_bd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL req_bd: got %b expected 0", F_bd);
        end
        step();
        clear_inputs();
        checks++;
        if (F_pc !== 32'h0000_4180) begin
            errors++;
            $display("[TB] FAIL req_handler: got %h expected %h", F_pc, 32'h0000_4180);
        end
    endtask

    task automatic test_eret();
        D_eret = 1'b1;
        EPC    = 32'h0000_3204;
        #1;
        checks++;
        if (F_flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL eret_flush: got %b expected 1", F_flush);
        end
        step();
        checks++;
        if (F_pc !== 32'h0000_3204) begin
            errors++;
            $display("[TB] FAIL eret_epc: got %h expected %h", F_pc, 32'h0000_3204);
        end
        // Stalled eret: hold and do not flush.
        EPC     = 32'h0000_3400;
        F_stall = 1'b1;
        #1;
        checks++;
        if (F_flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eret_stall_flush: got %b expected 0", F_flush);
        end
        step();
        checks++;
        if (F_pc !== 32'h0000_3204) begin
            errors++;
            $display("[TB] FAIL eret_stall_hold: got %h expected %h", F_pc, 32'h0000_3204);
        end
        // eret beats a simultaneous redirect.
        F_stall    = 1'b0;
        EPC        = 32'h0000_3300;
        D_redirect = 1'b1;
        D_target   = 32'h0000_7000;
        step();
        clear_inputs();
        checks++;
        if (F_pc !== 32'h0000_3300) begin
            errors++;
            $display("[TB] FAIL eret_over_redirect: got %h expected %h", F_pc, 32'h0000_3300);
        end
    endtask

    task automatic test_wrap();
        jump_to(32'h0000_3001);
        checks++;
        if (F_pc !== 32'h0000_3001) begin
            errors++;
            $display("[TB] FAIL misaligned_load: got %h expected %h", F_pc, 32'h0000_3001);
        end
        step();
        checks++;
        if (F_pc !== 32'h0000_3005) begin
            errors++;
            $display("[TB] FAIL misaligned_inc: got %h expected %h", F_pc, 32'h0000_3005);
        end
        jump_to(32'hFFFF_FFFC);
        checks++;
        if (F_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap_top: got %h expected %h", F_pc, 32'hFFFF_FFFC);
        end
        step();
        checks++;
        if (F_pc !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got %h expected %h", F_pc, 32'h0000_0000);
        end
        step();
        checks++;
        if (F_pc !== 32'h0000_0004) begin
            errors++;
            $display("[TB] FAIL wrap_after: got %h expected %h", F_pc, 32'h0000_0004);
        end
    endtask

    task automatic test_reset_midrun();
        reset      = 1'b1;
        Req        = 1'b1;
        D_eret     = 1'b1;
        EPC        = 32'h0000_3204;
        D_redirect = 1'b1;
        D_target   = 32'h0000_3100;
        step();
        checks++;
        if (F_pc !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL reset_mid_pc: got %h expected %h", F_pc, 32'h0000_3000);
        end
        reset = 1'b0;
        clear_inputs();
        step();
        checks++;
        if (F_pc !== 32'h0000_3004) begin
            errors++;
            $display("[TB] FAIL reset_mid_next: got %h expected %h", F_pc, 32'h0000_3004);
        end
    endtask

    // Scenario sequence; each task leaves inputs cleared for the next one.
    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_req_priority();
        test_eret();
        test_wrap();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_f_pc_unit
